clock_time_setter: RTL and testbench

Operator time-set controller for the 24-hour BCD digital clock. It captures the clock's current hours and minutes and lets the operator edit hours, then minutes, with two button pulses. It then writes the edited time back to the clock counter through a one-cycle load strobe. It sits between the push-button front end (debounced, one-cycle pulses) and the clock counter's load/hold inputs.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/clock_time_setter_bcd_pair_inc.sv | 39 +++
 rtl/clock_time_setter.sv | 123 ++++++++++++
 tb/tb_clock_time_setter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the clock time-set path.
// Pure declarations: no logic, no latency.
package clock_pkg;

  localparam int DIGIT_W = 4;

  localparam int HR_MAX_MS  = 2;
  localparam int HR_MAX_LS  = 3;
  localparam int MIN_MAX_MS = 5;
  localparam int MIN_MAX_LS = 9;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_HR  = 2'd1,
    EDIT_MIN = 2'd2,
    COMMIT   = 2'd3
  } state_t;

endpackage

// File: rtl/clock_time_setter_bcd_pair_inc.sv
// Two-digit BCD incrementer wrapping to 00 past MAX_MS:MAX_LS.
// Combinational, zero latency; out-of-range input also wraps to 00.
module bcd_pair_inc
  import clock_pkg::*;
#(
  parameter int MAX_MS = 5,
  parameter int MAX_LS = 9
) (
  input  logic [DIGIT_W-1:0] cur_ms,
  input  logic [DIGIT_W-1:0] cur_ls,
  output logic [DIGIT_W-1:0] nxt_ms,
  output logic [DIGIT_W-1:0] nxt_ls
);

  localparam logic [7:0] MAX_VAL = 8'(MAX_MS * 10 + MAX_LS);

  logic [7:0] val;
  logic       bad_digit;
  logic       wrap;

  always_comb begin
    val       = 8'(cur_ms) * 8'd10 + 8'(cur_ls);
    bad_digit = (cur_ms > 4'd9) || (cur_ls > 4'd9);
    // The top value and anything beyond it (captured garbage) both land on 00.
    wrap      = bad_digit || (val >= MAX_VAL);
    nxt_ms    = cur_ms;
    nxt_ls    = cur_ls;
    if (wrap) begin
      nxt_ms = '0;
      nxt_ls = '0;
    end else if (cur_ls == 4'd9) begin
      nxt_ms = cur_ms + 4'd1;
      nxt_ls = '0;
    end else begin
      nxt_ls = cur_ls + 4'd1;
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// Operator time-set FSM: capture, edit hours then minutes, load back.
// Edits visible one cycle after a button pulse; idle edits abandon after TIMEOUT cycles.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int TIMEOUT    = 30,
  parameter int BLINK_HALF = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_btn,
  input  logic               inc_btn,
  input  logic [DIGIT_W-1:0] cur_ms_hr,
  input  logic [DIGIT_W-1:0] cur_ls_hr,
  input  logic [DIGIT_W-1:0] cur_ms_min,
  input  logic [DIGIT_W-1:0] cur_ls_min,
  output logic [DIGIT_W-1:0] set_ms_hr,
  output logic [DIGIT_W-1:0] set_ls_hr,
  output logic [DIGIT_W-1:0] set_ms_min,
  output logic [DIGIT_W-1:0] set_ls_min,
  output logic               load,
  output logic               hold,
  output logic               blink_hr,
  output logic               blink_min
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF + 1) : 1;

  state_t          state;
  state_t          state_nxt;
  logic            editing;
  logic            any_btn;
  logic            timeout_hit;
  logic [TW-1:0]   tmo_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            phase;
  logic [DIGIT_W-1:0] hr_ms_inc, hr_ls_inc, min_ms_inc, min_ls_inc;

  bcd_pair_inc #(.MAX_MS(HR_MAX_MS), .MAX_LS(HR_MAX_LS)) u_hr_inc (
    .cur_ms (set_ms_hr),
    .cur_ls (set_ls_hr),
    .nxt_ms (hr_ms_inc),
    .nxt_ls (hr_ls_inc)
  );

  bcd_pair_inc #(.MAX_MS(MIN_MAX_MS), .MAX_LS(MIN_MAX_LS)) u_min_inc (
    .cur_ms (set_ms_min),
    .cur_ls (set_ls_min),
    .nxt_ms (min_ms_inc),
    .nxt_ls (min_ls_inc)
  );

  assign editing     = (state == EDIT_HR) || (state == EDIT_MIN);
  assign any_btn     = set_btn || inc_btn;
  assign timeout_hit = editing && !any_btn && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (set_btn) state_nxt = EDIT_HR;
      EDIT_HR:  if (set_btn) state_nxt = EDIT_MIN;
                else if (timeout_hit) state_nxt = IDLE;
      EDIT_MIN: if (set_btn) state_nxt = COMMIT;
                else if (timeout_hit) state_nxt = IDLE;
      COMMIT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hold      = (state != IDLE);
    load      = (state == COMMIT);
    blink_hr  = (state == EDIT_HR) && phase;
    blink_min = (state == EDIT_MIN) && phase;
  end

  // Any button keeps the edit alive; leaving the edit states parks the count at 0.
  always_ff @(posedge clk) begin
    if (reset || !editing || any_btn || timeout_hit) tmo_cnt <= '0;
    else                                           tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Phase restarts low on every state change so each field starts visible.
  always_ff @(posedge clk) begin
    if (reset || !editing || (state_nxt != state)) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // set_btn has priority: an inc in the same cycle as set is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      set_ms_hr  <= '0;
      set_ls_hr  <= '0;
      set_ms_min <= '0;
      set_ls_min <= '0;
    end else if (state == IDLE && set_btn) begin
      set_ms_hr  <= cur_ms_hr;
      set_ls_hr  <= cur_ls_hr;
      set_ms_min <= cur_ms_min;
      set_ls_min <= cur_ls_min;
    end else if (state == EDIT_HR && inc_btn && !set_btn) begin
      set_ms_hr <= hr_ms_inc;
      set_ls_hr <= hr_ls_inc;
    end else if (state == EDIT_MIN && inc_btn && !set_btn) begin
      set_ms_min <= min_ms_inc;
      set_ls_min <= min_ls_inc;
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed plus random stimulus against an arithmetic model of the time-set controller.
module tb_clock_time_setter;

  localparam int TIMEOUT    = 30;
  localparam int BLINK_HALF = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] cur_ms_hr = '0, cur_ls_hr = '0, cur_ms_min = '0, cur_ls_min = '0;
  logic [3:0] set_ms_hr, set_ls_hr, set_ms_min, set_ls_min;
  logic       load, hold, blink_hr, blink_min;

  int errors = 0;
  int checks = 0;

  // model: mode 0 idle, 1 hours, 2 minutes, 3 commit
  int m_mode = 0;
  int m_tmo  = 0;
  int m_fcyc = 0;
  int md[4]  = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  clock_time_setter #(.TIMEOUT(TIMEOUT), .BLINK_HALF(BLINK_HALF)) dut (
    .clk        (clk),
    .reset      (reset),
    .set_btn    (set_btn),
    .inc_btn    (inc_btn),
    .cur_ms_hr  (cur_ms_hr),
    .cur_ls_hr  (cur_ls_hr),
    .cur_ms_min (cur_ms_min),
    .cur_ls_min (cur_ls_min),
    .set_ms_hr  (set_ms_hr),
    .set_ls_hr  (set_ls_hr),
    .set_ms_min (set_ms_min),
    .set_ls_min (set_ls_min),
    .load       (load),
    .hold       (hold),
    .blink_hr   (blink_hr),
    .blink_min  (blink_min)
  );

  function automatic logic [15:0] dut_time();
    return {set_ms_hr, set_ls_hr, set_ms_min, set_ls_min};
  endfunction

  function automatic logic [15:0] model_time();
    return {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pair increment from the value rules: top value or garbage -> 00, else +1.
  task automatic bump(inout int ms, inout int ls, input int maxv);
    int v;
    v = ms * 10 + ls;
    if (ms > 9 || ls > 9 || v >= maxv) v = 0;
    else v = v + 1;
    ms = v / 10;
    ls = v % 10;
  endtask

  task automatic model_edge(input logic s, input logic i, input logic r);
    int a, b;
    if (r) begin
      m_mode = 0; m_tmo = 0; m_fcyc = 0; md = '{0, 0, 0, 0};
    end else begin
      case (m_mode)
        0: if (s) begin
             m_mode = 1; m_tmo = 0; m_fcyc = 0;
             md = '{int'(cur_ms_hr), int'(cur_ls_hr), int'(cur_ms_min), int'(cur_ls_min)};
           end
        1, 2: begin
          if (s) begin
            m_mode = (m_mode == 1) ? 2 : 3; m_tmo = 0; m_fcyc = 0;
          end else begin
            m_fcyc++;
            if (i) begin
              m_tmo = 0;
              if (m_mode == 1) begin a = md[0]; b = md[1]; bump(a, b, 23); md[0] = a; md[1] = b; end
              else             begin a = md[2]; b = md[3]; bump(a, b, 59); md[2] = a; md[3] = b; end
            end else begin
              m_tmo++;
              if (m_tmo >= TIMEOUT) begin m_mode = 0; m_tmo = 0; m_fcyc = 0; end
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic step(input logic s, input logic i, input logic r);
    bit ph;
    set_btn = s; inc_btn = i; reset = r;
    @(posedge clk);
    #1;
    model_edge(s, i, r);
    ph = ((m_fcyc / BLINK_HALF) % 2) == 1;
    chk("hold",      16'(hold),      16'(m_mode != 0));
    chk("load",      16'(load),      16'(m_mode == 3));
    chk("blink_hr",  16'(blink_hr),  16'(m_mode == 1 && ph));
    chk("blink_min", 16'(blink_min), 16'(m_mode == 2 && ph));
    chk("set_time",  dut_time(),     model_time());
    set_btn = 1'b0; inc_btn = 1'b0; reset = 1'b0;
  endtask

  task automatic set_cur(input logic [15:0] t);
    {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = t;
  endtask

  initial begin
    // reset
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset_time", dut_time(), 16'h0000);
    chk("reset_hold", 16'(hold), 16'h0);

    // capture 13:45 and watch the hour blink
    set_cur(16'h1345);
    step(1, 0, 0);
    chk("capture", dut_time(), 16'h1345);
    chk("enter_hold", 16'(hold), 16'h1);
    chk("enter_blink", 16'(blink_hr), 16'h0);
    step(0, 0, 0);
    chk("blink_on", 16'(blink_hr), 16'h1);
    step(0, 0, 0);
    chk("blink_off", 16'(blink_hr), 16'h0);
    step(0, 0, 1);

    // hour wrap from 22, minute wrap from 58
    set_cur(16'h2258);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("hr_23", dut_time(), 16'h2358);
    step(0, 1, 0);
    chk("hr_00", dut_time(), 16'h0058);
    step(1, 0, 0);
    chk("min_blink_reset", 16'(blink_min), 16'h0);
    step(0, 1, 0);
    chk("min_59", dut_time(), 16'h0059);
    step(0, 1, 0);
    chk("min_00", dut_time(), 16'h0000);
    step(1, 0, 0);
    step(0, 0, 0);

    // 09 -> 10 in both fields
    set_cur(16'h0909);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("carry_09", dut_time(), 16'h1010);
    step(0, 0, 1);

    // full sequence from 07:29
    set_cur(16'h0729);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("commit_load", 16'(load), 16'h1);
    chk("commit_hold", 16'(hold), 16'h1);
    chk("commit_time", dut_time(), 16'h0832);
    step(0, 0, 0);
    chk("after_load", 16'(load), 16'h0);
    chk("after_hold", 16'(hold), 16'h0);

    // set and inc together in hours: advance, hour untouched
    set_cur(16'h1111);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("set_wins_time", dut_time(), 16'h1111);
    chk("set_wins_state", 16'(blink_min | hold), 16'h1);

    // timeout in minutes
    for (int k = 0; k < TIMEOUT; k++) step(0, 0, 0);
    chk("timeout_hold", 16'(hold), 16'h0);
    chk("timeout_time", dut_time(), 16'h1111);

    // reset mid hour edit
    set_cur(16'h0530);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("abort_hold", 16'(hold), 16'h0);
    chk("abort_load", 16'(load), 16'h0);

    // invalid capture 2F:7A
    set_cur(16'h2F7A);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("invalid_wrap", dut_time(), 16'h0000);
    step(0, 0, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      set_cur(16'($urandom));
      step(r < 8, (r >= 8 && r < 45) || r == 5, r == 99);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
